// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer: owns the instruction-memory PC, the ALU write
// strobe, and resolution of unconditional and flag-conditional jumps.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | im_addr=pc, instruction word captured into ir at the edge
// DECODE | jump condition evaluated from ir_op and registered flags
// EXEC   | ALU strobe / PC update / halt decision
// HALT   | stopped on a HALT opcode, waiting for start
module pc_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int PROG_LAST = 24,
    parameter int OP_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic [OP_W-1:0]   im_op,
    input  logic [ADDR_W-1:0] im_target,
    input  logic              flag_we,
    input  logic              z_in,
    input  logic              n_in,
    input  logic              c_in,
    output logic [ADDR_W-1:0] im_addr,
    output logic              alu_we,
    output logic              jump_taken,
    output logic              addr_err,
    output logic              busy,
    output logic              halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_JEQ  = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_JNE  = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_JGT  = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_JLT  = OP_W'(4'hC);
    localparam logic [OP_W-1:0] OP_JCS  = OP_W'(4'hD);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(4'hF);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LAST);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   ir_op;
    logic [ADDR_W-1:0] ir_target;
    logic              z_flag, n_flag, c_flag;
    logic              take;
    logic              cond;
    logic              target_bad;
    logic [ADDR_W-1:0] pc_inc;
    logic              exec_go;

    always_comb begin
        cond = 1'b0;
        case (ir_op)
            OP_JMP:  cond = 1'b1;
            OP_JEQ:  cond = z_flag;
            OP_JNE:  cond = !z_flag;
            OP_JGT:  cond = !z_flag && !n_flag;
            OP_JLT:  cond = n_flag;
            OP_JCS:  cond = c_flag;
            default: cond = 1'b0;
        endcase
    end

    assign target_bad = (ir_target > LAST_ADDR);
    assign pc_inc     = (pc == LAST_ADDR) ? '0 : pc + ADDR_W'(1);
    assign exec_go    = (state == S_EXEC) && !stall;

    assign im_addr    = pc;
    assign alu_we     = exec_go && (ir_op == OP_ALU);
    assign jump_taken = exec_go && take;
    assign addr_err   = exec_go && take && target_bad;
    assign busy       = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted     = (state == S_HALT);

    // Flags track the ALU regardless of sequencer state or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            c_flag <= 1'b0;
        end else if (flag_we) begin
            z_flag <= z_in;
            n_flag <= n_in;
            c_flag <= c_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir_op     <= '0;
            ir_target <= '0;
            take      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!stall) begin
                        ir_op     <= im_op;
                        ir_target <= im_target;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Sampled before any same-edge flag update lands.
                    if (!stall) begin
                        take  <= cond;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (ir_op == OP_HALT) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_FETCH;
                            if (take) pc <= target_bad ? '0 : ir_target;
                            else      pc <= pc_inc;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
